// File: rtl/iob_timer_cmp_pkg.sv
// Shared configuration for the compare timer: default sizes and channel mode encoding.
package iob_timer_cmp_pkg;

  localparam int DATA_W_DEF  = 64;
  localparam int N_CH_DEF    = 4;
  localparam int PRESC_W_DEF = 16;

  typedef enum logic {
    CMP_ONESHOT  = 1'b0,
    CMP_PERIODIC = 1'b1
  } cmp_mode_e;

endpackage

// File: rtl/iob_timer_cmp_ch.sv
// One compare channel: tracks an absolute target, raises a sticky flag on hit.
// Strobes arrive already qualified by clock enable; tick_i already excludes clear.
module iob_timer_cmp_ch
  import iob_timer_cmp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] cnt_i,
  input  logic              tick_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] val_i,
  input  logic              periodic_i,
  input  logic              en_i,
  input  logic              ack_i,
  output logic              irq_o
);

  logic [DATA_W-1:0] target_q, target_d;
  logic [DATA_W-1:0] period_q, period_d;
  logic              armed_q, armed_d;
  cmp_mode_e         mode_q, mode_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] cnt_nxt;
  logic              hit;

  assign cnt_nxt = cnt_i + 1'b1;
  assign hit     = armed_q & en_i & tick_i & (cnt_nxt == target_q);

  always_comb begin
    target_d = target_q;
    period_d = period_q;
    armed_d  = armed_q;
    mode_d   = mode_q;
    irq_d    = irq_q;
    if (clr_i) begin
      armed_d = 1'b0;
    end else if (load_i) begin
      if (val_i != '0) begin
        period_d = val_i;
        target_d = cnt_i + val_i;
        armed_d  = 1'b1;
        mode_d   = cmp_mode_e'(periodic_i);
      end else begin
        armed_d = 1'b0;
      end
    end else if (hit) begin
      if (mode_q == CMP_PERIODIC) target_d = target_q + period_q;
      else                        armed_d  = 1'b0;
    end
    // Set beats acknowledge; a load in the hit cycle swallows the hit.
    if (ack_i) irq_d = 1'b0;
    if (hit && !load_i && !clr_i) irq_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      target_q <= '0;
      period_q <= '0;
      armed_q  <= 1'b0;
      mode_q   <= CMP_ONESHOT;
      irq_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      period_q <= period_d;
      armed_q  <= armed_d;
      mode_q   <= mode_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/iob_timer_cmp.sv
// Prescaled free-running counter with strobe-sampled read-back, sticky wrap flag
// and N_CH compare channels driving sticky interrupt lines.
module iob_timer_cmp
  import iob_timer_cmp_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_CH    = N_CH_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk_i,
  input  logic               cke_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic               rstrb_i,
  output logic [DATA_W-1:0]  time_o,
  output logic               ovf_o,
  input  logic [N_CH-1:0]    cmp_wr_i,
  input  logic [DATA_W-1:0]  cmp_val_i,
  input  logic [N_CH-1:0]    cmp_periodic_i,
  input  logic [N_CH-1:0]    cmp_en_i,
  input  logic [N_CH-1:0]    irq_ack_i,
  output logic [N_CH-1:0]    irq_o
);

  logic [DATA_W-1:0]  cnt_q, cnt_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [DATA_W-1:0]  time_q, time_d;
  logic               ovf_q, ovf_d;
  logic               presc_wrap;
  logic               tick;

  // ">=" so that lowering presc_i below the running count ticks immediately.
  assign presc_wrap = (pcnt_q >= presc_i);
  assign tick       = cke_i & en_i & ~clr_i & presc_wrap;

  always_comb begin
    cnt_d  = cnt_q;
    pcnt_d = pcnt_q;
    ovf_d  = ovf_q;
    time_d = rstrb_i ? cnt_q : time_q;
    if (clr_i) begin
      cnt_d  = '0;
      pcnt_d = '0;
      ovf_d  = 1'b0;
    end else if (en_i) begin
      if (presc_wrap) begin
        pcnt_d = '0;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) ovf_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      pcnt_q <= '0;
      time_q <= '0;
      ovf_q  <= 1'b0;
    end else if (cke_i) begin
      cnt_q  <= cnt_d;
      pcnt_q <= pcnt_d;
      time_q <= time_d;
      ovf_q  <= ovf_d;
    end
  end

  assign time_o = time_q;
  assign ovf_o  = ovf_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    iob_timer_cmp_ch #(
      .DATA_W(DATA_W)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .cnt_i      (cnt_q),
      .tick_i     (tick),
      .clr_i      (cke_i & clr_i),
      .load_i     (cke_i & cmp_wr_i[k]),
      .val_i      (cmp_val_i),
      .periodic_i (cmp_periodic_i[k]),
      .en_i       (cmp_en_i[k]),
      .ack_i      (cke_i & irq_ack_i[k]),
      .irq_o      (irq_o[k])
    );
  end

endmodule
